// File: rtl/decoder_seq_n_if.sv
// -----------------------------------------------------------------------------
// decoder_seq_n_if
// Bundle of the control, select and decode signals of decoder_seq_n.
//   en        : global enable (0 forces outputs inactive)
//   mode      : 0 = direct decode, 1 = auto-scan
//   sel_valid : select request valid
//   sel       : index to decode (SEL_W bits)
//   sel_ready : select accepted when sel_valid && sel_ready
//   dwell     : cycles-minus-one each index is held while scanning
//   out       : registered one-hot (or all-zero) decode
//   out_valid : out holds a legal one-hot value
//   cur_idx   : index currently driven
//   scan_wrap : one-cycle pulse when the scan wraps back to index 0
//   err       : out-of-range select flag
// The decoder attaches through the slave modport; the driver of requests
// uses the master modport.
// -----------------------------------------------------------------------------
interface decoder_seq_n_if #(
   parameter int NUM_OUT = 4,
   parameter int DWELL_W = 4
);
   localparam int SEL_W = $clog2(NUM_OUT);

   logic               en;
   logic               mode;
   logic               sel_valid;
   logic [SEL_W-1:0]   sel;
   logic               sel_ready;
   logic [DWELL_W-1:0] dwell;
   logic [NUM_OUT-1:0] out;
   logic               out_valid;
   logic [SEL_W-1:0]   cur_idx;
   logic               scan_wrap;
   logic               err;

   modport slave (
      input  en, mode, sel_valid, sel, dwell,
      output sel_ready, out, out_valid, cur_idx, scan_wrap, err
   );

   modport master (
      output en, mode, sel_valid, sel, dwell,
      input  sel_ready, out, out_valid, cur_idx, scan_wrap, err
   );
endinterface

// File: rtl/decoder_seq_n.sv
// -----------------------------------------------------------------------------
// decoder_seq_n
// Registered NUM_OUT-way one-hot decoder with a valid/ready select port,
// an out-of-range error flag and an auto-scan mode that walks every output
// for a programmable dwell time. Outputs are registered so they are
// glitch-free when used as chip-selects or row strobes.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   dec_if : decoder_seq_n_if.slave (en, mode, sel_valid, sel, sel_ready,
//            dwell, out, out_valid, cur_idx, scan_wrap, err)
//
// Build option:
//   DECODER_SEQ_STICKY_ERR_EN - when defined, err stays set after an
//   out-of-range select until reset or a cycle with en=0; otherwise err is a
//   one-cycle pulse per out-of-range accept.
// -----------------------------------------------------------------------------
module decoder_seq_n #(
   parameter int NUM_OUT = 4,
   parameter int DWELL_W = 4
) (
   input logic             clk,
   input logic             rst_n,
   decoder_seq_n_if.slave  dec_if
);
   localparam int SEL_W = $clog2(NUM_OUT);
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_OUT - 1);

`ifdef DECODER_SEQ_STICKY_ERR_EN
   localparam bit STICKY_ERR = 1'b1;
`else
   localparam bit STICKY_ERR = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      SCAN = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_OUT-1:0] out_q, out_d;
   logic               out_valid_q, out_valid_d;
   logic [SEL_W-1:0]   cur_idx_q, cur_idx_d;
   logic               scan_wrap_q, scan_wrap_d;
   logic               err_q, err_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;

   // One extra bit so the range test stays meaningful when NUM_OUT is a
   // power of two (every sel value is then legal).
   logic [SEL_W:0] sel_ext;
   logic           sel_in_range;

   assign sel_ext      = {1'b0, dec_if.sel};
   assign sel_in_range = (sel_ext < (SEL_W+1)'(NUM_OUT));

   assign dec_if.sel_ready = dec_if.en && !dec_if.mode;

   // Next-state: en=0 dominates, then mode, then a direct select.
   always_comb begin
      state_d     = state_q;
      cur_idx_d   = cur_idx_q;
      out_valid_d = out_valid_q;
      cnt_d       = cnt_q;
      dwell_d     = dwell_q;
      scan_wrap_d = 1'b0;
      err_d       = STICKY_ERR ? err_q : 1'b0;

      if (!dec_if.en) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
         cnt_d       = '0;
         err_d       = 1'b0;
      end else if (dec_if.mode) begin
         if (state_q != SCAN) begin
            state_d     = SCAN;
            cur_idx_d   = '0;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            dwell_d     = dec_if.dwell;
         end else if (cnt_q == dwell_q) begin
            // Index finished its dwell: move on and resample dwell so a
            // change takes effect at the start of the next index.
            cnt_d   = '0;
            dwell_d = dec_if.dwell;
            if (cur_idx_q == LAST_IDX) begin
               cur_idx_d   = '0;
               scan_wrap_d = 1'b1;
            end else begin
               cur_idx_d = cur_idx_q + 1'b1;
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         cnt_d = '0;
         if (dec_if.sel_valid) begin
            if (sel_in_range) begin
               state_d     = HOLD;
               cur_idx_d   = dec_if.sel;
               out_valid_d = 1'b1;
            end else begin
               // Illegal index: blank outputs but keep the last cur_idx.
               state_d     = IDLE;
               out_valid_d = 1'b0;
               err_d       = 1'b1;
            end
         end else if (state_q == SCAN) begin
            state_d = HOLD;
         end
      end
   end

   // Decode from the next index and activity bit, so out can only ever be
   // one-hot or zero and out_valid always equals |out.
   generate
      for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_decode
         assign out_d[gi] = out_valid_d && (cur_idx_d == SEL_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         cur_idx_q   <= '0;
         scan_wrap_q <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         dwell_q     <= '0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         cur_idx_q   <= cur_idx_d;
         scan_wrap_q <= scan_wrap_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
         dwell_q     <= dwell_d;
      end
   end

   assign dec_if.out       = out_q;
   assign dec_if.out_valid = out_valid_q;
   assign dec_if.cur_idx   = cur_idx_q;
   assign dec_if.scan_wrap = scan_wrap_q;
   assign dec_if.err       = err_q;
endmodule

// File: doc/decoder_seq_n.md
Name: decoder_seq_n

Overview:
Parametrised, registered successor to the team's 2-to-4 gate-level decoder. Generalises to NUM_OUT one-hot outputs with a valid/ready select interface, a range-error flag, and an auto-scan mode that walks the outputs with a programmable dwell time. Used to drive chip-selects or row strobes where outputs must be glitch-free (registered) and time-multiplexed.

Parameters:
NUM_OUT, 4, number of decoded outputs; legal range 2..64, power of two not required
SEL_W, $clog2(NUM_OUT) (derived localparam, not overridable), select width
DWELL_W, 4, width of dwell count input

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
en  input  1  global enable; 0 forces outputs inactive
mode  input  1  0 = direct decode, 1 = auto-scan
sel_valid  input  1  select request valid
sel  input  SEL_W  index to decode
sel_ready  output  1  select accepted when sel_valid && sel_ready
dwell  input  DWELL_W  cycles-minus-one each index is held in scan mode
out  output  NUM_OUT  registered one-hot (or all-zero) decode
out_valid  output  1  out holds a legal one-hot value
cur_idx  output  SEL_W  index currently driven
scan_wrap  output  1  one-cycle pulse when scan advances from NUM_OUT-1 to 0
err  output  1  out-of-range select flag

Behaviour:
- Reset: synchronous on rst_n=0 at clk edge; overrides all other inputs, including mid-scan and mid-handshake. Reset values: out=0, out_valid=0, cur_idx=0, scan_wrap=0, err=0, dwell counter=0, state=IDLE.
- States: IDLE (out=0), HOLD (direct value held), SCAN.
- sel_ready is combinational: en && !mode. It is independent of sel_valid.
- Direct accept (sel_valid && sel_ready), sel < NUM_OUT:
  - Next cycle: out = 1<<sel, out_valid=1, cur_idx=sel, state HOLD.
  - Latency is 1 cycle. Back-to-back accepts are allowed every cycle.
- Direct accept, sel >= NUM_OUT:
  - Next cycle: out=0, out_valid=0, cur_idx unchanged, state IDLE, err=1 for one cycle (see macro).
- HOLD with no accept: out, out_valid and cur_idx are held indefinitely.
- Scan entry: en=1 && mode=1 while in IDLE or HOLD.
  - Next cycle: state SCAN, cur_idx=0, out=1<<0, out_valid=1, dwell counter=0.
  - dwell is sampled at the start of each index.
- SCAN operation:
  - The counter increments each cycle.
  - When counter == sampled dwell: counter -> 0 and cur_idx advances. Each index is driven for dwell+1 cycles; dwell=0 advances every cycle.
  - Wrap: cur_idx NUM_OUT-1 -> 0, with scan_wrap=1 in the same cycle cur_idx becomes 0.
- Scan exit: mode 1->0 with en=1.
  - Next cycle: state HOLD, current out and cur_idx retained, counter cleared. sel_ready=1 from the cycle mode=0 is seen.
- Disable: en=0 in any state.
  - Next cycle: state IDLE, out=0, out_valid=0, scan_wrap=0, cur_idx retained.
  - sel_ready=0, so no accept can occur.
- Simultaneous events:
  - sel_valid while mode=1 is ignored (sel_ready=0).
  - en=0 takes priority over mode and sel.
  - A mode change and a dwell change in the same cycle: the mode change wins; the new dwell is sampled at the scan start.
- out is always one-hot or zero, never multi-hot. out_valid == |out at all times.

Optional Feature:
DECODER_SEQ_STICKY_ERR_EN
- Defined: err is sticky once set. It clears only on reset or on any cycle with en=0 (clears the next cycle). Further errors keep it at 1.
- Undefined: err is a one-cycle pulse per out-of-range accept.
- Decode, scan and handshake behaviour is identical in both builds.

Test Plan:
- Reset, then direct sweep: NUM_OUT=4, en=1, mode=0, sel_valid=1, sel=0,1,2,3 on consecutive cycles -> out = 0001, 0010, 0100, 1000, each one cycle after acceptance; out_valid=1; cur_idx matches.
- Range error: NUM_OUT=6, sel=7 accepted -> next cycle out=000000, out_valid=0, err=1 for 1 cycle (non-sticky). With DECODER_SEQ_STICKY_ERR_EN, err stays 1 until en=0.
- Scan: NUM_OUT=4, dwell=2, mode=1 for 14 cycles -> each index held 3 cycles (0,1,2,3,0); scan_wrap high exactly once, at the cycle cur_idx returns to 0; dwell=0 gives a new index every cycle.
- Exit and hold: scan in progress at idx 2, mode->0 -> out stays 0100. sel_valid=1, sel=1 with sel_ready=1 -> next cycle out=0010. sel_valid in scan mode -> sel_ready=0, no change.
- Disable: en=0 mid-scan -> next cycle out=0, out_valid=0, cur_idx held. en=1 with mode=1 -> restart at idx 0.
- Reset mid-operation: rst_n=0 for 1 cycle during scan and during a direct accept -> all outputs at reset values next cycle; asynchronous rst_n glitches between edges have no effect.
